// File: rtl/branch_resolve_pipe.sv
// Branch resolution unit: evaluates branch conditions, computes next PC, flags mispredicts,
// and carries results through an elastic valid/ready pipeline with saturating statistics.
package lib_pkg;
    typedef enum logic [3:0] {
        CMP_BEQ  = 4'h0,
        CMP_BNE  = 4'h1,
        CMP_BLT  = 4'h4,
        CMP_BGE  = 4'h5,
        CMP_BLTU = 4'h6,
        CMP_BGEU = 4'h7
    } cmp_type_t;
endpackage

module branch_resolve_pipe
    import lib_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  cmp_type_t        cmp_type,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm,
    input  logic             pred_taken,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic [WIDTH-1:0] next_pc,
    output logic             mispredict,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mis_count
);

    typedef struct packed {
        logic             taken;
        logic             mispredict;
        logic             illegal;
        logic [WIDTH-1:0] next_pc;
        logic [TAG_W-1:0] tag;
    } slot_t;

    slot_t             eval_d;
    slot_t             slot_q [STAGES];
    logic [STAGES-1:0] vld_q;
    logic [STAGES:0]   rdy;
    logic              cond;
    logic              legal;
    logic [WIDTH-1:0]  pc_plus4;
    logic [WIDTH-1:0]  target;
    logic              out_hs;

    always_comb begin
        pc_plus4 = pc + WIDTH'(4);
        target   = pc + imm;
        cond     = 1'b0;
        legal    = 1'b1;
        case (cmp_type)
            CMP_BEQ:  cond = (in0 == in1);
            CMP_BNE:  cond = (in0 != in1);
            CMP_BLT:  cond = ($signed(in0) <  $signed(in1));
            CMP_BGE:  cond = ($signed(in0) >= $signed(in1));
            CMP_BLTU: cond = (in0 <  in1);
            CMP_BGEU: cond = (in0 >= in1);
            default:  legal = 1'b0;
        endcase
        eval_d.taken      = legal && cond;
        eval_d.mispredict = legal && (cond != pred_taken);
        eval_d.illegal    = !legal;
        eval_d.next_pc    = (legal && cond) ? target : pc_plus4;
        eval_d.tag        = tag;
    end

    // Ready ripples back from the consumer so a full pipe can shift without bubbles.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int unsigned k = 0; k < STAGES; k++) begin
            rdy[STAGES-1-k] = !vld_q[STAGES-1-k] || rdy[STAGES-k];
        end
    end

    assign in_ready   = rdy[0] && !flush;
    assign out_valid  = vld_q[STAGES-1] && !flush;
    assign out_hs     = out_valid && out_ready;
    assign taken      = slot_q[STAGES-1].taken;
    assign mispredict = slot_q[STAGES-1].mispredict;
    assign illegal    = slot_q[STAGES-1].illegal;
    assign next_pc    = slot_q[STAGES-1].next_pc;
    assign out_tag    = slot_q[STAGES-1].tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                slot_q[i] <= '0;
            end
        end else if (flush) begin
            vld_q <= '0;
        end else begin
            if (rdy[0]) begin
                vld_q[0] <= in_valid;
                if (in_valid) begin
                    slot_q[0] <= eval_d;
                end
            end
            for (int unsigned i = 1; i < STAGES; i++) begin
                if (rdy[i]) begin
                    vld_q[i] <= vld_q[i-1];
                    if (vld_q[i-1]) begin
                        slot_q[i] <= slot_q[i-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count  <= '0;
            mis_count <= '0;
        end else if (clr_cnt) begin
            br_count  <= '0;
            mis_count <= '0;
        end else if (out_hs) begin
            if (!illegal && br_count != '1) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (mispredict && mis_count != '1) begin
                mis_count <= mis_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/branch_resolve_pipe.md
Name: branch_resolve_pipe

Overview:
- Pipelined, parametrised branch-resolution unit for the RISC-V core, placed between the execute-stage operand muxes and the fetch redirect logic.
- Evaluates the six branch conditions (BEQ/BNE/BLT/BGE/BLTU/BGEU from lib_pkg::cmp_type_t) on WIDTH-bit operands and computes the branch target and next PC.
- Flags mispredictions against the fetch-stage prediction and keeps saturating branch/mispredict counters.
- Elastic valid/ready pipeline of configurable depth, with a flush input.

Parameters:
WIDTH, 32, operand/PC width in bits (>=8)
STAGES, 2, pipeline register stages from input to output (1..4)
TAG_W, 5, width of the opaque tag carried with each branch
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  kill all in-flight branches
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request
cmp_type  in  cmp_type_t  branch condition
in0  in  WIDTH  rs1 operand
in1  in  WIDTH  rs2 operand
pc  in  WIDTH  branch instruction PC
imm  in  WIDTH  sign-extended B-immediate
pred_taken  in  1  fetch prediction
tag  in  TAG_W  opaque ID, returned unchanged
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
taken  out  1  resolved direction
next_pc  out  WIDTH  taken ? target : pc+4
mispredict  out  1  taken != pred_taken
illegal  out  1  cmp_type not one of the six legal encodings
out_tag  out  TAG_W  tag of the result
clr_cnt  in  1  synchronous counter clear
br_count  out  CNT_W  retired legal branches
mis_count  out  CNT_W  retired mispredicts

Behaviour:
- Reset (asynchronous, active-high): all stage-valid bits 0, so out_valid=0. taken, mispredict, illegal = 0. next_pc, out_tag = 0. br_count, mis_count = 0. Reset mid-operation discards all in-flight entries.
- Evaluation at the input, combinationally:
  - BEQ: in0==in1. BNE: in0!=in1.
  - BLT/BGE: signed compare. BLTU/BGEU: unsigned compare.
  - target = pc+imm; pc+4 is also computed. Both wrap modulo 2^WIDTH, with no overflow flag.
  - Illegal cmp_type: illegal=1, taken=0, mispredict=0, next_pc=pc+4.
- Pipeline: STAGES register slots, each with its own valid bit.
  - ready[i] = !valid[i] || ready[i+1], where ready[STAGES] = out_ready.
  - in_ready = ready[0] && !flush.
  - Transfer happens on valid&&ready. A slot holds its data when stalled.
  - Latency with no backpressure: a request accepted at edge N appears on out_valid in the cycle after edge N+STAGES-1. Example: STAGES=1 gives out_valid in the cycle following acceptance.
  - Throughput is 1 result/cycle when out_ready=1. Full = all slots valid and out_ready=0, which makes in_ready=0.
  - Simultaneous accept and retire in a full pipe proceeds: a bubble-free shift.
- Flush:
  - While flush=1: in_ready=0 and out_valid is masked to 0, so no handshake and no counting.
  - The next edge clears every valid bit.
  - Counters are unaffected.
- Counters, evaluated on the output handshake (out_valid && out_ready):
  - br_count += 1 if !illegal.
  - mis_count += 1 if mispredict.
  - Both saturate at 2^CNT_W-1.
  - clr_cnt zeroes both on the next edge and takes priority over an increment in the same cycle.
- Output data is stable while out_valid=1 and out_ready=0.

Test Plan:
- STAGES=2, BLT, in0=0xFFFFFFFF, in1=1, pc=0x100, imm=0xFFFFFFF0, pred_taken=0 -> 2 cycles later: taken=1, next_pc=0xF0, mispredict=1, br_count=1, mis_count=1. Same request as BLTU -> taken=0, next_pc=0x104, mispredict=0.
- Back-to-back 8 requests with out_ready=1 -> 8 consecutive out_valid cycles, tags in order 0..7, no bubbles. Then hold out_ready=0 -> in_ready falls after 2 further accepts, outputs stable, and resume retires in order.
- pc=0xFFFFFFFC, BEQ equal, imm=8 -> next_pc=0x4 (wrap). Not taken -> next_pc=0x0.
- cmp_type=4'hF -> illegal=1, taken=0, mispredict=0, br_count unchanged.
- 2 branches in flight, assert flush 1 cycle -> in_ready=0 and out_valid=0 that cycle, no later outputs, counters unchanged. Assert rst mid-stream -> all outputs and counters 0 immediately, asynchronously.
- CNT_W=4: retire 20 mispredicting branches -> both counters saturate at 15. clr_cnt coincident with a retire -> both counters read 0 next cycle.
